seven_seg_scanner: RTL and testbench

Registered, time-multiplexed driver for the board's 4-digit common-anode seven-segment display. It consumes the four BCD result digits produced by the calculator's arithmetic stages (digit1 leftmost … digit4 rightmost) and scans them onto the display. New digit sets are applied only at frame boundaries, so a frame never shows a mix of old and new digits. It also blanks leading zeros and marks out-of-range digits.

---
 rtl/seven_seg_scanner.sv | 164 ++++++++++++++++
 tb/tb_seven_seg_scanner.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed driver for a 4-digit common-anode
// seven-segment display. Digit sets are double-buffered so a new set only
// takes effect at a frame boundary. Leading zeros can be blanked and
// out-of-range BCD values are shown as a dash.
module seven_seg_scanner #(
  parameter int REFRESH_DIV = 100000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic [3:0] digit4,
  input  logic       blank_lz,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_done
);

  localparam int            CW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  // Level that turns a line off: high for active-low wiring, low otherwise.
  localparam logic          OFF_LVL = (ACTIVE_LOW != 0);

  // Active-high gfedcba pattern for one BCD value; 10..15 show a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b1000000;
    endcase
    return s;
  endfunction

  // Digit arrays are indexed by scan position: [0] is digit1 (leftmost).
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0][3:0] pend_dig_q, pend_dig_d;
  logic            pend_blz_q, pend_blz_d;
  logic            pend_vld_q, pend_vld_d;
  logic [3:0][3:0] disp_dig_q, disp_dig_d;
  logic            disp_blz_q, disp_blz_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            fd_stage_q;
  logic            frame_done_q;

  logic            wrap;
  logic            boundary;
  logic [3:0][3:0] load_dig;
  logic [2:0]      lead_zero;
  logic [3:0]      cur_dig;
  logic            cur_blank;

  assign load_dig = {digit4, digit3, digit2, digit1};
  assign wrap     = (cnt_q == CNT_MAX);
  assign boundary = wrap && (idx_q == 2'd3);

  // Divider and scan index advance.
  always_comb begin
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    idx_d = wrap ? idx_q + 2'd1 : idx_q;
  end

  // Double buffer: loads park in the pending set; the display set only
  // changes at the boundary. A load on the boundary itself skips the
  // pending stage and supersedes anything still waiting there.
  always_comb begin
    pend_dig_d = pend_dig_q;
    pend_blz_d = pend_blz_q;
    pend_vld_d = pend_vld_q;
    disp_dig_d = disp_dig_q;
    disp_blz_d = disp_blz_q;
    if (boundary) begin
      if (load) begin
        disp_dig_d = load_dig;
        disp_blz_d = blank_lz;
        pend_vld_d = 1'b0;
      end else if (pend_vld_q) begin
        disp_dig_d = pend_dig_q;
        disp_blz_d = pend_blz_q;
        pend_vld_d = 1'b0;
      end
    end else if (load) begin
      pend_dig_d = load_dig;
      pend_blz_d = blank_lz;
      pend_vld_d = 1'b1;
    end
  end

  // A slot is a leading zero when it and every digit to its left are 0;
  // the rightmost digit is always shown. Dashes are non-zero here.
  always_comb begin
    lead_zero[0] = (disp_dig_q[0] == 4'd0);
    lead_zero[1] = lead_zero[0] && (disp_dig_q[1] == 4'd0);
    lead_zero[2] = lead_zero[1] && (disp_dig_q[2] == 4'd0);
    cur_dig      = disp_dig_q[idx_q];
    cur_blank    = disp_blz_q && (idx_q != 2'd3) && lead_zero[idx_q];
  end

  // Next anode/segment pattern for the slot currently selected, in
  // active-high form first and then mapped to the board polarity.
  always_comb begin
    an_d  = cur_blank ? 4'b0000 : (4'b1000 >> idx_q);
    seg_d = cur_blank ? 7'b0000000 : seg_decode(cur_dig);
    an_d  = an_d  ^ {4{OFF_LVL}};
    seg_d = seg_d ^ {7{OFF_LVL}};
  end

  // Scan state and digit buffers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      idx_q      <= 2'd0;
      pend_dig_q <= '0;
      pend_blz_q <= 1'b0;
      pend_vld_q <= 1'b0;
      disp_dig_q <= '0;
      disp_blz_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pend_dig_q <= pend_dig_d;
      pend_blz_q <= pend_blz_d;
      pend_vld_q <= pend_vld_d;
      disp_dig_q <= disp_dig_d;
      disp_blz_q <= disp_blz_d;
    end
  end

  // Output registers. frame_done is delayed one extra stage so it lines up
  // with the first registered digit1 pattern of the new frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_q         <= {4{OFF_LVL}};
      seg_q        <= {7{OFF_LVL}};
      fd_stage_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      an_q         <= an_d;
      seg_q        <= seg_d;
      fd_stage_q   <= boundary;
      frame_done_q <= fd_stage_q;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = OFF_LVL;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: a cycle-count based reference model checked
// every cycle, plus directed scenarios with hand-computed patterns.
module tb_seven_seg_scanner;
  localparam int R = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [3:0] d1 = '0, d2 = '0, d3 = '0, d4 = '0;
  logic       blz = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_done;

  seven_seg_scanner #(.REFRESH_DIV(R), .ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .load(load),
    .digit1(d1), .digit2(d2), .digit3(d3), .digit4(d4),
    .blank_lz(blz), .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Active-high gfedcba glyphs indexed by digit value.
  logic [6:0] SEGT [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                            7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                            7'b1111111, 7'b1101111, 7'b1000000, 7'b1000000,
                            7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};

  // Reference model: t counts clock edges since reset; slot and frame
  // position come straight from t.
  int         t;
  int         md [4];
  bit         mblz;
  int         pd [4];
  bit         pblz;
  bit         pv;
  bit         bprev;
  logic [3:0] e_an  = 4'hF;
  logic [6:0] e_seg = 7'h7F;
  logic       e_fd  = 1'b0;

  task automatic exp_out(input int s, output logic [3:0] a, output logic [6:0] sg);
    bit blank;
    blank = 1'b0;
    if (mblz && s < 3) begin
      blank = 1'b1;
      for (int k = 0; k <= s; k++) if (md[k] != 0) blank = 1'b0;
    end
    a  = 4'hF;
    sg = 7'h7F;
    if (!blank) begin
      a[3-s] = 1'b0;
      sg     = ~SEGT[md[s]];
    end
  endtask

  always @(posedge clk) begin : model
    int s;
    bit bnd;
    if (reset) begin
      t = 0;
      for (int k = 0; k < 4; k++) begin md[k] = 0; pd[k] = 0; end
      mblz = 0; pblz = 0; pv = 0; bprev = 0;
      e_an = 4'hF; e_seg = 7'h7F; e_fd = 1'b0;
    end else begin
      s = (t / R) % 4;
      exp_out(s, e_an, e_seg);
      e_fd  = bprev;
      bnd   = ((t % (4 * R)) == 4 * R - 1);
      bprev = bnd;
      if (bnd) begin
        if (load) begin
          md[0] = d1; md[1] = d2; md[2] = d3; md[3] = d4; mblz = blz; pv = 0;
        end else if (pv) begin
          md = pd; mblz = pblz; pv = 0;
        end
      end else if (load) begin
        pd[0] = d1; pd[1] = d2; pd[2] = d3; pd[3] = d4; pblz = blz; pv = 1;
      end
      t++;
    end
  end

  // Every-cycle compare against the model.
  always @(posedge clk) begin
    #1;
    checks++;
    if ({an, seg, dp, frame_done} !== {e_an, e_seg, 1'b1, e_fd}) begin
      errors++;
      $display("FAIL model t=%0d an=%b seg=%b dp=%b fd=%b expected an=%b seg=%b dp=1 fd=%b",
               t, an, seg, dp, frame_done, e_an, e_seg, e_fd);
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b expected=%b", nm, got, exp);
    end
  endtask

  task automatic do_load(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d, input logic z);
    d1 = a; d2 = b; d3 = c; d4 = d; blz = z; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_fd();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (frame_done) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_fd got=timeout expected=frame_done");
  endtask

  logic [3:0] c_an  [4];
  logic [6:0] c_seg [4];

  // Called at the negedge where frame_done is high: records the four slots.
  task automatic cap();
    for (int k = 0; k < 4; k++) begin
      c_an[k]  = an;
      c_seg[k] = seg;
      repeat (R) @(negedge clk);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #2;
    chk("first_edge_an", 32'(an), 32'(4'b0111));
    chk("first_edge_seg", 32'(seg), 32'(7'b1000000));

    // Leading-zero blanking with zeros in front.
    wait_fd();
    do_load(4'd0, 4'd0, 4'd4, 4'd2, 1'b1);
    wait_fd();
    cap();
    chk("blz_d1_an", 32'(c_an[0]), 32'(4'b1111));
    chk("blz_d1_seg", 32'(c_seg[0]), 32'(7'b1111111));
    chk("blz_d2_an", 32'(c_an[1]), 32'(4'b1111));
    chk("blz_d3_an", 32'(c_an[2]), 32'(4'b1101));
    chk("blz_d3_seg", 32'(c_seg[2]), 32'(7'b0011001));
    chk("blz_d4_an", 32'(c_an[3]), 32'(4'b1110));
    chk("blz_d4_seg", 32'(c_seg[3]), 32'(7'b0100100));

    // All zeros, blanked then unblanked.
    do_load(4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    wait_fd();
    cap();
    chk("zero_blz_an", {c_an[0], c_an[1], c_an[2], c_an[3]}, 16'hFFFE);
    chk("zero_blz_seg4", 32'(c_seg[3]), 32'(7'b1000000));
    do_load(4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    wait_fd();
    cap();
    chk("zero_noblz_an", {c_an[0], c_an[1], c_an[2], c_an[3]}, 16'b0111_1011_1101_1110);
    chk("zero_noblz_seg", {c_seg[0], c_seg[1], c_seg[2], c_seg[3]},
        {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000});

    // Mid-frame load, then an overwriting load before the boundary.
    wait_fd();
    repeat (R) @(negedge clk);
    do_load(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
    repeat (R) @(negedge clk);
    chk("midframe_old_d3", {an, seg}, {4'b1101, 7'b1000000});
    do_load(4'd5, 4'd6, 4'd7, 4'd8, 1'b0);
    wait_fd();
    cap();
    chk("overwrite_an", {c_an[0], c_an[1], c_an[2], c_an[3]}, 16'b0111_1011_1101_1110);
    chk("overwrite_seg", {c_seg[0], c_seg[1], c_seg[2], c_seg[3]},
        {7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000});

    // Load exactly on the boundary cycle, with an older set still pending.
    do_load(4'd2, 4'd2, 4'd2, 4'd2, 1'b0);
    for (int i = 0; i < 64; i++) begin
      if ((t % (4 * R)) == 4 * R - 1) break;
      @(negedge clk);
    end
    do_load(4'd3, 4'd0, 4'd5, 4'd9, 1'b1);
    wait_fd();
    cap();
    chk("bnd_seg", {c_seg[0], c_seg[1], c_seg[2], c_seg[3]},
        {7'b0110000, 7'b1000000, 7'b0010010, 7'b0010000});
    wait_fd();
    cap();
    chk("bnd_kept_seg", {c_seg[0], c_seg[1], c_seg[2], c_seg[3]},
        {7'b0110000, 7'b1000000, 7'b0010010, 7'b0010000});

    // Out-of-range digit acts as a non-zero for blanking.
    do_load(4'd0, 4'd12, 4'd0, 4'd9, 1'b1);
    wait_fd();
    cap();
    chk("oor_an", {c_an[0], c_an[1], c_an[2], c_an[3]}, 16'b1111_1011_1101_1110);
    chk("oor_seg", {c_seg[1], c_seg[2], c_seg[3]}, {7'b0111111, 7'b1000000, 7'b0010000});

    // Reset mid-scan with a load pending.
    wait_fd();
    do_load(4'd7, 4'd7, 4'd7, 4'd7, 1'b0);
    repeat (R + 1) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_outs", {an, seg, dp, frame_done}, {4'b1111, 7'b1111111, 1'b1, 1'b0});
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #2;
    chk("rst_release_d1", {an, seg}, {4'b0111, 7'b1000000});

    // Randomized loads against the model.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(9) == 0) begin
        d1 = 4'($urandom_range(15)); d2 = 4'($urandom_range(15));
        d3 = 4'($urandom_range(15)); d4 = 4'($urandom_range(15));
        blz = 1'($urandom_range(1));
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
    end
    @(negedge clk);
    load = 1'b0;
    repeat (2 * 4 * R) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
